// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: control inputs from the pipeline, the combinational
// instruction-ROM port, and the IF/ID register outputs toward decode.
//   master : the fetch stage (drives imem_pc and the IF/ID/status signals)
//   slave  : the surrounding pipeline and ROM (drives stall/redirect/imem_instr)
interface fetch_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_instr;
   logic [31:0] imem_pc;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic [31:0] fetch_count;
   logic        misalign;

   modport master (
      input  stall, redirect, redirect_pc, imem_instr,
      output imem_pc, id_pc, id_instr, id_valid, fetch_count, misalign
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_instr,
      input  imem_pc, id_pc, id_instr, id_valid, fetch_count, misalign
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC, addresses a combinational word-aligned
// ROM with it, and captures the returned word into the IF/ID register.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset, overrides every other input
//   bus  - fetch_stage_if.master: stall/redirect/redirect_pc/imem_instr in;
//          imem_pc, id_pc, id_instr, id_valid, fetch_count, misalign out
// Every output is a register; there is no combinational input-to-output path.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic         clk,
   input  logic         rst,
   fetch_stage_if.master bus
);

   logic [31:0] pc_q,          pc_d;
   logic [31:0] id_pc_q,       id_pc_d;
   logic [31:0] id_instr_q,    id_instr_d;
   logic        id_valid_q,    id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        misalign_q,    misalign_d;

   // Priority: redirect > stall > advance. A redirect flushes IF/ID with a
   // bubble whose id_pc records the discarded fetch address.
   always_comb begin
      pc_d          = pc_q;
      id_pc_d       = id_pc_q;
      id_instr_d    = id_instr_q;
      id_valid_d    = id_valid_q;
      fetch_count_d = fetch_count_q;
      misalign_d    = misalign_q;

      if (bus.redirect) begin
         pc_d       = {bus.redirect_pc[31:2], 2'b00};
         id_pc_d    = pc_q;
         id_instr_d = NOP_INSTR;
         id_valid_d = 1'b0;
         if (bus.redirect_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end
      end else if (!bus.stall) begin
         pc_d          = pc_q + 32'd4;
         id_pc_d       = pc_q;
         id_instr_d    = bus.imem_instr;
         id_valid_d    = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         id_pc_q       <= 32'h0000_0000;
         id_instr_q    <= NOP_INSTR;
         id_valid_q    <= 1'b0;
         fetch_count_q <= 32'h0000_0000;
         misalign_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         id_pc_q       <= id_pc_d;
         id_instr_q    <= id_instr_d;
         id_valid_q    <= id_valid_d;
         fetch_count_q <= fetch_count_d;
         misalign_q    <= misalign_d;
      end
   end

   assign bus.imem_pc     = pc_q;
   assign bus.id_pc       = id_pc_q;
   assign bus.id_instr    = id_instr_q;
   assign bus.id_valid    = id_valid_q;
   assign bus.fetch_count = fetch_count_q;
   assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   logic rst_w;
   int   vectors;
   int   miscompares;

   fetch_stage_if bus ();
   fetch_stage_if bus_w ();

   // Arbitrary but address-unique ROM contents.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   assign bus.imem_instr   = rom_word(bus.imem_pc);
   assign bus_w.imem_instr = rom_word(bus_w.imem_pc);

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
      .clk (clk),
      .rst (rst_w),
      .bus (bus_w.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the RESET_PC=0 instance, stepped once per edge.
   logic [31:0] m_pc, m_id_pc, m_id_instr, m_cnt;
   logic        m_valid, m_mis;

   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
      rst              = r;
      bus.stall        = s;
      bus.redirect     = rd;
      bus.redirect_pc  = rp;
      if (r) begin
         m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = NOP; m_valid = 1'b0;
         m_cnt = 32'h0; m_mis = 1'b0;
      end else if (rd) begin
         m_id_pc    = m_pc;
         m_id_instr = NOP;
         m_valid    = 1'b0;
         m_pc       = rp - (rp % 4);
         if (rp % 4 != 0) m_mis = 1'b1;
      end else if (!s) begin
         m_id_pc    = m_pc;
         m_id_instr = rom_word(m_pc);
         m_valid    = 1'b1;
         m_pc       = m_pc + 4;
         m_cnt      = m_cnt + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.imem_pc !== 32'h0) begin miscompares++; $display("FAIL reset_imem_pc got %h want %h", bus.imem_pc, 32'h0); end
      vectors++; if (bus.id_pc !== 32'h0) begin miscompares++; $display("FAIL reset_id_pc got %h want %h", bus.id_pc, 32'h0); end
      vectors++; if (bus.id_instr !== NOP) begin miscompares++; $display("FAIL reset_id_instr got %h want %h", bus.id_instr, NOP); end
      vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid got %b want 0", bus.id_valid); end
      vectors++; if (bus.fetch_count !== 32'h0) begin miscompares++; $display("FAIL reset_fetch_count got %0d want 0", bus.fetch_count); end
      vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %b want 0", bus.misalign); end
   endtask

   task automatic test_run();
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0);
         vectors++; if (bus.id_pc !== 32'(i * 4)) begin miscompares++; $display("FAIL run_id_pc[%0d] got %h want %h", i, bus.id_pc, 32'(i * 4)); end
         vectors++; if (bus.id_instr !== rom_word(32'(i * 4))) begin miscompares++; $display("FAIL run_id_instr[%0d] got %h want %h", i, bus.id_instr, rom_word(32'(i * 4))); end
         vectors++; if (bus.id_valid !== 1'b1) begin miscompares++; $display("FAIL run_id_valid[%0d] got %b want 1", i, bus.id_valid); end
      end
      vectors++; if (bus.fetch_count !== 32'd3) begin miscompares++; $display("FAIL run_fetch_count got %0d want 3", bus.fetch_count); end
      vectors++; if (bus.imem_pc !== 32'hC) begin miscompares++; $display("FAIL run_imem_pc got %h want %h", bus.imem_pc, 32'hC); end
   endtask

   task automatic test_stall();
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         vectors++; if (bus.imem_pc !== 32'h8) begin miscompares++; $display("FAIL stall_imem_pc[%0d] got %h want %h", i, bus.imem_pc, 32'h8); end
         vectors++; if (bus.id_pc !== 32'h4) begin miscompares++; $display("FAIL stall_id_pc[%0d] got %h want %h", i, bus.id_pc, 32'h4); end
         vectors++; if (bus.id_instr !== rom_word(32'h4)) begin miscompares++; $display("FAIL stall_id_instr[%0d] got %h want %h", i, bus.id_instr, rom_word(32'h4)); end
         vectors++; if (bus.fetch_count !== 32'd2) begin miscompares++; $display("FAIL stall_fetch_count[%0d] got %0d want 2", i, bus.fetch_count); end
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.id_pc !== 32'h8) begin miscompares++; $display("FAIL release_id_pc got %h want %h", bus.id_pc, 32'h8); end
      vectors++; if (bus.id_instr !== rom_word(32'h8)) begin miscompares++; $display("FAIL release_id_instr got %h want %h", bus.id_instr, rom_word(32'h8)); end
   endtask

   // Continues from test_stall: PC = 0xC, fetch_count = 3.
   task automatic test_redirect();
      step(1'b0, 1'b0, 1'b1, 32'h40);
      vectors++; if (bus.imem_pc !== 32'h40) begin miscompares++; $display("FAIL redir_imem_pc got %h want %h", bus.imem_pc, 32'h40); end
      vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL redir_id_valid got %b want 0", bus.id_valid); end
      vectors++; if (bus.id_instr !== NOP) begin miscompares++; $display("FAIL redir_id_instr got %h want %h", bus.id_instr, NOP); end
      vectors++; if (bus.id_pc !== 32'hC) begin miscompares++; $display("FAIL redir_id_pc got %h want %h", bus.id_pc, 32'hC); end
      vectors++; if (bus.fetch_count !== 32'd3) begin miscompares++; $display("FAIL redir_fetch_count got %0d want 3", bus.fetch_count); end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.id_pc !== 32'h40) begin miscompares++; $display("FAIL redir_target_id_pc got %h want %h", bus.id_pc, 32'h40); end
      vectors++; if (bus.id_valid !== 1'b1) begin miscompares++; $display("FAIL redir_target_id_valid got %b want 1", bus.id_valid); end
      vectors++; if (bus.id_instr !== rom_word(32'h40)) begin miscompares++; $display("FAIL redir_target_id_instr got %h want %h", bus.id_instr, rom_word(32'h40)); end
   endtask

   task automatic test_misalign();
      vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_before got %b want 0", bus.misalign); end
      step(1'b0, 1'b1, 1'b1, 32'h43);
      vectors++; if (bus.imem_pc !== 32'h40) begin miscompares++; $display("FAIL misalign_imem_pc got %h want %h", bus.imem_pc, 32'h40); end
      vectors++; if (bus.misalign !== 1'b1) begin miscompares++; $display("FAIL misalign_set got %b want 1", bus.misalign); end
      vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL misalign_id_valid got %b want 0", bus.id_valid); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0);
         vectors++; if (bus.misalign !== 1'b1) begin miscompares++; $display("FAIL misalign_sticky[%0d] got %b want 1", i, bus.misalign); end
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_clear got %b want 0", bus.misalign); end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h100);
      vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_first got %b want 0", bus.id_valid); end
      step(1'b0, 1'b0, 1'b1, 32'h200);
      vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_second got %b want 0", bus.id_valid); end
      vectors++; if (bus.imem_pc !== 32'h200) begin miscompares++; $display("FAIL b2b_imem_pc got %h want %h", bus.imem_pc, 32'h200); end
      vectors++; if (bus.id_pc !== 32'h100) begin miscompares++; $display("FAIL b2b_id_pc got %h want %h", bus.id_pc, 32'h100); end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.id_pc !== 32'h200) begin miscompares++; $display("FAIL b2b_target_id_pc got %h want %h", bus.id_pc, 32'h200); end
      vectors++; if (bus.fetch_count !== 32'd2) begin miscompares++; $display("FAIL b2b_fetch_count got %0d want 2", bus.fetch_count); end
   endtask

   task automatic test_wrap();
      rst_w = 1'b0;
      @(posedge clk); #1;
      vectors++; if (bus_w.id_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_id_pc got %h want %h", bus_w.id_pc, 32'hFFFF_FFFC); end
      vectors++; if (bus_w.imem_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_imem_pc got %h want %h", bus_w.imem_pc, 32'h0); end
      @(posedge clk); #1;
      vectors++; if (bus_w.fetch_count !== 32'd2) begin miscompares++; $display("FAIL wrap_fetch_count got %0d want 2", bus_w.fetch_count); end
      vectors++; if (bus_w.id_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_id_pc2 got %h want %h", bus_w.id_pc, 32'h0); end
      vectors++; if (bus_w.id_instr !== rom_word(32'h0)) begin miscompares++; $display("FAIL wrap_id_instr2 got %h want %h", bus_w.id_instr, rom_word(32'h0)); end
      rst_w = 1'b1;
   endtask

   task automatic test_mid_reset();
      step(1'b0, 1'b0, 1'b1, 32'h81);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      vectors++; if (bus.imem_pc !== 32'h0) begin miscompares++; $display("FAIL rst_stall_imem_pc got %h want 0", bus.imem_pc); end
      vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_stall_id_valid got %b want 0", bus.id_valid); end
      vectors++; if (bus.fetch_count !== 32'h0) begin miscompares++; $display("FAIL rst_stall_fetch_count got %0d want 0", bus.fetch_count); end
      vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL rst_stall_misalign got %b want 0", bus.misalign); end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0F07);
      step(1'b1, 1'b0, 1'b1, 32'h0000_0F07);
      vectors++; if (bus.imem_pc !== 32'h0) begin miscompares++; $display("FAIL rst_redir_imem_pc got %h want 0", bus.imem_pc); end
      vectors++; if (bus.id_instr !== NOP) begin miscompares++; $display("FAIL rst_redir_id_instr got %h want %h", bus.id_instr, NOP); end
      vectors++; if (bus.id_pc !== 32'h0) begin miscompares++; $display("FAIL rst_redir_id_pc got %h want 0", bus.id_pc); end
      vectors++; if (bus.misalign !== 1'b0) begin miscompares++; $display("FAIL rst_redir_misalign got %b want 0", bus.misalign); end
      vectors++; if (bus.fetch_count !== 32'h0) begin miscompares++; $display("FAIL rst_redir_fetch_count got %0d want 0", bus.fetch_count); end
   endtask

   task automatic test_random();
      logic        r, s, rd;
      logic [31:0] rp;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 59) == 0);
         s  = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 6) == 0);
         rp = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC);
         step(r, s, rd, rp);
         vectors++; if (bus.imem_pc !== m_pc) begin miscompares++; $display("FAIL rnd_imem_pc[%0d] got %h want %h", i, bus.imem_pc, m_pc); end
         vectors++; if (bus.id_pc !== m_id_pc) begin miscompares++; $display("FAIL rnd_id_pc[%0d] got %h want %h", i, bus.id_pc, m_id_pc); end
         vectors++; if (bus.id_instr !== m_id_instr) begin miscompares++; $display("FAIL rnd_id_instr[%0d] got %h want %h", i, bus.id_instr, m_id_instr); end
         vectors++; if (bus.id_valid !== m_valid) begin miscompares++; $display("FAIL rnd_id_valid[%0d] got %b want %b", i, bus.id_valid, m_valid); end
         vectors++; if (bus.fetch_count !== m_cnt) begin miscompares++; $display("FAIL rnd_fetch_count[%0d] got %0d want %0d", i, bus.fetch_count, m_cnt); end
         vectors++; if (bus.misalign !== m_mis) begin miscompares++; $display("FAIL rnd_misalign[%0d] got %b want %b", i, bus.misalign, m_mis); end
      end
   endtask

   initial begin
      vectors           = 0;
      miscompares       = 0;
      rst               = 1'b1;
      rst_w             = 1'b1;
      bus.stall         = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_pc   = 32'h0;
      bus_w.stall       = 1'b0;
      bus_w.redirect    = 1'b0;
      bus_w.redirect_pc = 32'h0;
      m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = NOP; m_valid = 1'b0;
      m_cnt = 32'h0; m_mis = 1'b0;
      @(posedge clk); #1;

      test_reset();
      test_run();
      test_stall();
      test_redirect();
      test_misalign();
      test_back_to_back();
      test_wrap();
      test_mid_reset();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
